// File: rtl/button_debouncer.sv
// Per-button synchroniser and stability counter for raw pushbutton pins.
// Outputs the debounced level in pin polarity, a pressed view, and one-cycle press/release strobes.
module button_debouncer #(
    parameter int N_BTN           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_WID         = $clog2(DEBOUNCE_CYCLES + 1),
    parameter int ACTIVE_LOW      = 1
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse
);

    localparam logic               IDLE    = (ACTIVE_LOW != 0);
    localparam logic [CNT_WID-1:0] CNT_MAX = CNT_WID'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0]   sync_q [SYNC_STAGES];
    logic [N_BTN-1:0]   sync_d [SYNC_STAGES];
    logic [CNT_WID-1:0] cnt_q  [N_BTN];
    logic [CNT_WID-1:0] cnt_d  [N_BTN];
    logic [N_BTN-1:0]   db_q, db_d;
    logic [N_BTN-1:0]   press_q, press_d;
    logic [N_BTN-1:0]   release_q, release_d;
    logic [N_BTN-1:0]   sample;

    always_comb begin
        sync_d[0] = btn_raw;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        sample = sync_q[SYNC_STAGES-1];

        db_d      = db_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            cnt_d[i] = '0;
            // A sample matching the current level discards any partial count.
            if (sample[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]      = sample[i];
                    press_d[i]   = (sample[i] != IDLE);
                    release_d[i] = (sample[i] == IDLE);
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_WID'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= {N_BTN{IDLE}};
            end
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            db_q      <= {N_BTN{IDLE}};
            press_q   <= '0;
            release_q <= '0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_d[s];
            end
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            db_q      <= db_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_db        = db_q;
    assign btn_pressed   = db_q ^ {N_BTN{IDLE}};
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
// Directed scenarios check exact cycle timing; a random phase compares against a sample-window model.
module tb_button_debouncer;

  localparam int SS = 2;
  localparam int DC = 4;
  localparam logic [3:0] IDLE_V = 4'hF;

  logic       CLK;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_db;
  logic [3:0] btn_pressed;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;

  int n_checks = 0;
  int n_errors = 0;

  // model state: most recent captured raw values first
  logic [3:0] hist_q[$];
  logic [3:0] m_db;
  logic [3:0] m_press;
  logic [3:0] m_rel;

  button_debouncer #(
    .N_BTN(4),
    .SYNC_STAGES(SS),
    .DEBOUNCE_CYCLES(DC),
    .ACTIVE_LOW(1)
  ) dut (
    .CLK(CLK),
    .rst(rst),
    .btn_raw(btn_raw),
    .btn_db(btn_db),
    .btn_pressed(btn_pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  // clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // A button flips when the DC most recent synchronised samples all differ from its level.
  // The synchronised sample at an edge is the raw value captured SS edges earlier.
  function automatic void model_step(input logic [3:0] raw, input logic r);
    logic [3:0] v;
    logic all_diff;
    m_press = 4'h0;
    m_rel   = 4'h0;
    if (r) begin
      hist_q.delete();
      for (int j = 0; j < SS; j++) hist_q.push_front(IDLE_V);
      m_db = IDLE_V;
    end else begin
      hist_q.push_front(raw);
      while (hist_q.size() > SS + DC) void'(hist_q.pop_back());
      if (hist_q.size() == SS + DC) begin
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          for (int j = SS; j < SS + DC; j++) begin
            v = hist_q[j];
            if (v[i] == m_db[i]) all_diff = 1'b0;
          end
          if (all_diff) begin
            m_db[i] = ~m_db[i];
            if (m_db[i] == 1'b0) m_press[i] = 1'b1;
            else m_rel[i] = 1'b1;
          end
        end
      end
    end
  endfunction

  // driver: apply inputs, take one rising edge, return at the following falling edge
  task automatic tick(input logic [3:0] raw, input logic r);
    btn_raw = raw;
    rst     = r;
    @(posedge CLK);
    model_step(raw, r);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    tick(4'hF, 1'b1);
    tick(4'hF, 1'b1);
    n_checks++;
    if (btn_db !== 4'hF) begin n_errors++; $display("FAIL reset_db got %h want %h", btn_db, 4'hF); end
    n_checks++;
    if (btn_pressed !== 4'h0) begin n_errors++; $display("FAIL reset_pressed got %h want %h", btn_pressed, 4'h0); end
    n_checks++;
    if (press_pulse !== 4'h0) begin n_errors++; $display("FAIL reset_press got %h want %h", press_pulse, 4'h0); end
    n_checks++;
    if (release_pulse !== 4'h0) begin n_errors++; $display("FAIL reset_release got %h want %h", release_pulse, 4'h0); end
  endtask

  task automatic test_single_press();
    int rel_cnt;
    logic [3:0] exp_db;
    logic [3:0] exp_p;
    for (int t = 1; t <= 10; t++) begin
      tick(4'h7, 1'b0);
      exp_db = (t >= 6) ? 4'h7 : 4'hF;
      exp_p  = (t == 6) ? 4'h8 : 4'h0;
      n_checks++;
      if (btn_db !== exp_db || press_pulse !== exp_p || release_pulse !== 4'h0) begin
        n_errors++;
        $display("FAIL single_press t=%0d db=%h press=%h rel=%h want db=%h press=%h rel=0",
                 t, btn_db, press_pulse, release_pulse, exp_db, exp_p);
      end
    end
    n_checks++;
    if (btn_pressed !== 4'h8) begin n_errors++; $display("FAIL single_pressed got %h want %h", btn_pressed, 4'h8); end
    rel_cnt = 0;
    for (int t = 1; t <= 8; t++) begin
      tick(4'hF, 1'b0);
      if (release_pulse[3]) rel_cnt++;
    end
    n_checks++;
    if (rel_cnt != 1 || btn_db !== 4'hF) begin
      n_errors++;
      $display("FAIL single_release pulses=%0d db=%h want 1 and %h", rel_cnt, btn_db, 4'hF);
    end
  endtask

  task automatic test_glitch();
    for (int t = 1; t <= 11; t++) begin
      tick((t <= 3) ? 4'hE : 4'hF, 1'b0);
      n_checks++;
      if (btn_db !== 4'hF || press_pulse !== 4'h0 || release_pulse !== 4'h0) begin
        n_errors++;
        $display("FAIL glitch t=%0d db=%h press=%h rel=%h want F,0,0", t, btn_db, press_pulse, release_pulse);
      end
    end
  endtask

  task automatic test_toggle();
    logic [3:0] raw;
    logic [3:0] exp_p;
    for (int t = 1; t <= 16; t++) begin
      raw = 4'hF;
      if (t > 6 || (t % 2) == 1) raw[1] = 1'b0;
      tick(raw, 1'b0);
      exp_p = (t == 12) ? 4'h2 : 4'h0;
      n_checks++;
      if (press_pulse !== exp_p || release_pulse !== 4'h0) begin
        n_errors++;
        $display("FAIL toggle t=%0d press=%h rel=%h want %h,0", t, press_pulse, release_pulse, exp_p);
      end
    end
    for (int t = 1; t <= 8; t++) tick(4'hF, 1'b0);
  endtask

  task automatic test_simultaneous();
    for (int t = 1; t <= 8; t++) begin
      tick(4'h0, 1'b0);
      n_checks++;
      if (press_pulse !== ((t == 6) ? 4'hF : 4'h0) || release_pulse !== 4'h0) begin
        n_errors++;
        $display("FAIL simul_press t=%0d press=%h rel=%h", t, press_pulse, release_pulse);
      end
    end
    for (int t = 1; t <= 8; t++) begin
      tick(4'hF, 1'b0);
      n_checks++;
      if (release_pulse !== ((t == 6) ? 4'hF : 4'h0) || press_pulse !== 4'h0) begin
        n_errors++;
        $display("FAIL simul_release t=%0d press=%h rel=%h", t, press_pulse, release_pulse);
      end
    end
    n_checks++;
    if (btn_db !== 4'hF) begin n_errors++; $display("FAIL simul_final_db got %h want %h", btn_db, 4'hF); end
  endtask

  task automatic test_reset_mid();
    for (int t = 1; t <= 3; t++) tick(4'hB, 1'b0);
    tick(4'hB, 1'b1);
    tick(4'hB, 1'b1);
    n_checks++;
    if (btn_db !== 4'hF || press_pulse !== 4'h0 || release_pulse !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_mid db=%h press=%h rel=%h want F,0,0", btn_db, press_pulse, release_pulse);
    end
    for (int t = 1; t <= 8; t++) begin
      tick(4'hB, 1'b0);
      n_checks++;
      if (press_pulse !== ((t == 6) ? 4'h4 : 4'h0) || btn_db !== ((t >= 6) ? 4'hB : 4'hF)) begin
        n_errors++;
        $display("FAIL reset_rearm t=%0d press=%h db=%h", t, press_pulse, btn_db);
      end
    end
    for (int t = 1; t <= 8; t++) tick(4'hF, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] raw;
    logic r;
    int hold;
    tick(4'hF, 1'b1);
    for (int seg = 0; seg < 300; seg++) begin
      raw  = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 7);
      r    = ($urandom_range(0, 59) == 0);
      for (int h = 0; h < hold; h++) begin
        tick(raw, (h == 0) ? r : 1'b0);
        n_checks++;
        if (btn_db !== m_db || btn_pressed !== (m_db ^ 4'hF) ||
            press_pulse !== m_press || release_pulse !== m_rel ||
            (press_pulse & release_pulse) !== 4'h0) begin
          n_errors++;
          $display("FAIL random seg=%0d db=%h pr=%h p=%h r=%h want db=%h pr=%h p=%h r=%h",
                   seg, btn_db, btn_pressed, press_pulse, release_pulse,
                   m_db, m_db ^ 4'hF, m_press, m_rel);
        end
      end
    end
  endtask

  initial begin
    btn_raw = 4'hF;
    rst     = 1'b1;
    m_db    = IDLE_V;
    m_press = 4'h0;
    m_rel   = 4'h0;
    @(negedge CLK);
    test_reset();
    test_single_press();
    test_glitch();
    test_toggle();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
